sm4_key_sched_ctrl: RTL and testbench
=====================================

Name: sm4_key_sched_ctrl

Overview:
Arbitrates key-load requests from up to NUM_REQ requesters onto the single SM4 key-expansion engine (keyexp), one expansion at a time. Holds MK stable on the engine for the full expansion and captures the 1024-bit round-key vector into a key slot. Serves stored round keys to the cipher datapath in encrypt order, or word-reversed for decrypt. Sits between the host/requester interfaces and the keyexp + round datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_SLOTS, 4, number of round-key storage slots (power of 2, 2..8)
TIMEOUT, 40, max cycles from launch to RK_READY before error

Ports:
CLK_i  in  1  clock
RST_N_i  in  1  asynchronous active-low reset
REQ_VALID_i  in  NUM_REQ  per-requester load request
REQ_MK_i  in  128*NUM_REQ  per-requester master key, requester r at [128r+127:128r]
REQ_SLOT_i  in  $clog2(NUM_SLOTS)*NUM_REQ  per-requester destination slot
REQ_READY_o  out  NUM_REQ  one-hot accept pulse; handshake completes on VALID&READY
KE_MK_o  out  128  master key to keyexp
KE_MK_VALID_o  out  1  launch pulse to keyexp
KE_RK_i  in  1024  round keys from keyexp, rk0 at [1023:992]
KE_RK_READY_i  in  1  keyexp completion
RD_SLOT_i  in  $clog2(NUM_SLOTS)  read slot select
RD_DEC_i  in  1  1 = decrypt order
RD_RK_o  out  1024  round keys of selected slot, registered
SLOT_VALID_o  out  NUM_SLOTS  slot holds a complete key
BUSY_o  out  1  expansion in progress
ERR_o  out  1  sticky timeout error

Behaviour:
- Reset: all outputs 0; slot storage and SLOT_VALID_o cleared; round-robin pointer = 0; state IDLE.
- Interface is fully synchronous to CLK_i; RST_N_i asserts asynchronously, deasserts synchronously.
- FSM: IDLE -> LAUNCH -> WAIT -> STORE -> IDLE.
- IDLE: if any REQ_VALID_i, pick requester by round-robin starting at pointer; pulse REQ_READY_o[g] for 1 cycle; latch MK and slot; clear SLOT_VALID_o[slot]; go LAUNCH. Pointer <= g+1 mod NUM_REQ.
- LAUNCH: KE_MK_o = latched MK (held stable from this cycle until exit of STORE); KE_MK_VALID_o = 1 for exactly this cycle; go WAIT.
- WAIT: timeout counter increments; on KE_RK_READY_i go STORE; if counter reaches TIMEOUT, set ERR_o, leave slot invalid, go IDLE.
- STORE: write KE_RK_i into slot; set SLOT_VALID_o[slot] the following cycle; go IDLE.
- Nominal launch-to-valid: 1 (LAUNCH) + 32 (engine) + 1 (STORE) = 34 cycles; request accept to SLOT_VALID_o high = 35 cycles.
- BUSY_o = 1 in LAUNCH, WAIT and STORE.
- KE_MK_o retains last key in IDLE (no toggling).
- No REQ_READY_o while BUSY_o; requests stay pending; VALID must hold until READY.
- Spurious KE_RK_READY_i in IDLE/LAUNCH is ignored.
- RD_RK_o: registered, 1-cycle latency from RD_SLOT_i/RD_DEC_i. Encrypt: slot content. Decrypt: 32-bit word i moved to word 31-i. Reads of a slot being rewritten return old content until the STORE write, then new content.
- A request targeting the slot being read invalidates it at accept; readers must gate on SLOT_VALID_o.
- Reset mid-expansion: returns to IDLE; all slots invalid.
- ERR_o is cleared only by reset.

Optional Feature:
SM4_KEY_ZEROIZE_EN: adds input ZEROIZE_i (1 bit). When high in any state, all slots are cleared to 0 next cycle, SLOT_VALID_o = 0, KE_MK_o = 0, FSM -> IDLE, and any pending STORE is discarded; a late KE_RK_READY_i is ignored. Without the macro, there is no port and slots clear only on reset.

Decomposition:
- Package sm4_pkg: FSM state enum, RK_W=1024, WORD_W=32, NUM_ROUNDS=32, MK_W=128.
- Sub-module rr_arbiter (NUM_REQ-wide round-robin grant with pointer update on accept) is natural. Slot storage and read mux stay in the top.

Test Plan:
- Single load: req0 MK=0123456789ABCDEFFEDCBA9876543210 to slot 1 -> REQ_READY_o[0] 1 cycle; KE_MK_VALID_o 1 cycle later; SLOT_VALID_o[1] 35 cycles after accept; RD_RK_o[1023:992]=F12186F9, RD_RK_o[31:0]=9124A012.
- Decrypt read of the same slot, RD_DEC_i=1 -> RD_RK_o[1023:992]=9124A012, RD_RK_o[31:0]=F12186F9, one cycle after select.
- All 4 requesters valid simultaneously -> grants in order 0,1,2,3, each 35 cycles apart; then req2+req0 valid -> grant 0 first (pointer wrapped).
- Engine stub never returns READY -> ERR_o=1 at TIMEOUT=40 cycles after LAUNCH; slot invalid; next request is accepted normally.
- Reset asserted in WAIT at cycle 10 -> all outputs 0 immediately; a late KE_RK_READY_i causes no slot write.
- (with SM4_KEY_ZEROIZE_EN) ZEROIZE_i during WAIT -> SLOT_VALID_o=0, RD_RK_o=0, FSM IDLE, BUSY_o=0 next cycle.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared widths, FSM state encoding and the round-key word-reversal helper
// used by the SM4 key-schedule controller.
package sm4_pkg;

    localparam int RK_W       = 1024;
    localparam int WORD_W     = 32;
    localparam int NUM_ROUNDS = 32;
    localparam int MK_W       = 128;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LAUNCH = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_STORE  = 2'd3;

    // rk0 lives in the top word; decrypt order needs rk31 there instead.
    function automatic logic [RK_W-1:0] rk_word_reverse(input logic [RK_W-1:0] rk);
        logic [RK_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            r[i*WORD_W +: WORD_W] = rk[(NUM_ROUNDS-1-i)*WORD_W +: WORD_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/sm4_key_sched_ctrl_rr_arbiter.sv
// Round-robin grant over the key-load requesters; the pointer moves past the
// winner only when the grant is actually accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               CLK_i,
    input  logic               RST_N_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   gidx_o,
    output logic               accept_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o  = '0;
        gidx_o   = '0;
        accept_o = 1'b0;
        ptr_d    = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                gidx_o = idx;
            end
        end
        if (found && en_i) begin
            accept_o        = 1'b1;
            grant_o[gidx_o] = 1'b1;
            ptr_d           = PTR_W'((int'(gidx_o) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-schedule controller: arbitrates MK loads onto keyexp, stores round keys
// per slot, serves them encrypt/decrypt ordered. Optional SM4_KEY_ZEROIZE_EN adds ZEROIZE_i.
module sm4_key_sched_ctrl
    import sm4_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 40
) (
    input  logic                                  CLK_i,
    input  logic                                  RST_N_i,
    input  logic [NUM_REQ-1:0]                    REQ_VALID_i,
    input  logic [MK_W*NUM_REQ-1:0]               REQ_MK_i,
    input  logic [$clog2(NUM_SLOTS)*NUM_REQ-1:0]  REQ_SLOT_i,
    output logic [NUM_REQ-1:0]                    REQ_READY_o,
    output logic [MK_W-1:0]                       KE_MK_o,
    output logic                                  KE_MK_VALID_o,
    input  logic [RK_W-1:0]                       KE_RK_i,
    input  logic                                  KE_RK_READY_i,
    input  logic [$clog2(NUM_SLOTS)-1:0]          RD_SLOT_i,
    input  logic                                  RD_DEC_i,
    output logic [RK_W-1:0]                       RD_RK_o,
    output logic [NUM_SLOTS-1:0]                  SLOT_VALID_o,
    output logic                                  BUSY_o,
`ifdef SM4_KEY_ZEROIZE_EN
    input  logic                                  ZEROIZE_i,
`endif
    output logic                                  ERR_o
);

    // state  | meaning
    // IDLE   | waiting for a request; accepts one and latches MK/slot
    // LAUNCH | one-cycle start pulse to keyexp
    // WAIT   | timeout down-counter running until keyexp completes
    // STORE  | round keys written into the latched slot

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [MK_W-1:0]    mk_q, mk_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [NUM_SLOTS-1:0] vld_q, vld_d;
    logic [RK_W-1:0]    mem_q [NUM_SLOTS];
    logic [RK_W-1:0]    mem_d [NUM_SLOTS];
    logic [RK_W-1:0]    rd_q, rd_d;

    logic               zeroize;
    logic               arb_en;
    logic               accept;
    logic [PTR_W-1:0]   gidx;
    logic [SLOT_W-1:0]  acc_slot;

`ifdef SM4_KEY_ZEROIZE_EN
    assign zeroize = ZEROIZE_i;
`else
    assign zeroize = 1'b0;
`endif

    assign arb_en = (state_q == ST_IDLE) && !zeroize;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .CLK_i    (CLK_i),
        .RST_N_i  (RST_N_i),
        .req_i    (REQ_VALID_i),
        .en_i     (arb_en),
        .grant_o  (REQ_READY_o),
        .gidx_o   (gidx),
        .accept_o (accept)
    );

    assign acc_slot = REQ_SLOT_i[int'(gidx)*SLOT_W +: SLOT_W];

    always_comb begin
        state_d = state_q;
        mk_d    = mk_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        vld_d   = vld_q;
        mem_d   = mem_q;
        rd_d    = RD_DEC_i ? rk_word_reverse(mem_q[RD_SLOT_i]) : mem_q[RD_SLOT_i];

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mk_d            = REQ_MK_i[int'(gidx)*MK_W +: MK_W];
                    slot_d          = acc_slot;
                    vld_d[acc_slot] = 1'b0;
                    state_d         = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Loaded so that the error lands exactly TIMEOUT cycles after LAUNCH.
                cnt_d   = CNT_W'(TIMEOUT - 2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (KE_RK_READY_i) begin
                    state_d = ST_STORE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STORE: begin
                mem_d[slot_q] = KE_RK_i;
                vld_d[slot_q] = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (zeroize) begin
            state_d = ST_IDLE;
            mk_d    = '0;
            vld_d   = '0;
            rd_d    = '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                mem_d[s] = '0;
            end
        end
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_q <= ST_IDLE;
            mk_q    <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            rd_q    <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                mem_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            mk_q    <= mk_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                mem_q[s] <= mem_d[s];
            end
        end
    end

    assign KE_MK_o       = mk_q;
    assign KE_MK_VALID_o = (state_q == ST_LAUNCH);
    assign BUSY_o        = (state_q != ST_IDLE);
    assign ERR_o         = err_q;
    assign SLOT_VALID_o  = vld_q;
    assign RD_RK_o       = rd_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Bench for sm4_key_sched_ctrl: keyexp stub plus a transaction-level reference
// model (slot contents, validity, grant order, timing per accepted request).
module tb_sm4_key_sched_ctrl;

    localparam int NR = 4;
    localparam int NS = 4;
    localparam logic [127:0] KMK = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic           CLK_i = 1'b0;
    logic           RST_N_i = 1'b0;
    logic [NR-1:0]  REQ_VALID_i = '0;
    logic [128*NR-1:0] REQ_MK_i = '0;
    logic [2*NR-1:0] REQ_SLOT_i = '0;
    logic [NR-1:0]  REQ_READY_o;
    logic [127:0]   KE_MK_o;
    logic           KE_MK_VALID_o;
    logic [1023:0]  KE_RK_i = '0;
    logic           KE_RK_READY_i = 1'b0;
    logic [1:0]     RD_SLOT_i = '0;
    logic           RD_DEC_i = 1'b0;
    logic [1023:0]  RD_RK_o;
    logic [NS-1:0]  SLOT_VALID_o;
    logic           BUSY_o;
    logic           ERR_o;
`ifdef SM4_KEY_ZEROIZE_EN
    logic           ZEROIZE_i = 1'b0;
`endif

    always #5 CLK_i = ~CLK_i;

    sm4_key_sched_ctrl #(.NUM_REQ(NR), .NUM_SLOTS(NS), .TIMEOUT(40)) dut (
        .CLK_i         (CLK_i),
        .RST_N_i       (RST_N_i),
        .REQ_VALID_i   (REQ_VALID_i),
        .REQ_MK_i      (REQ_MK_i),
        .REQ_SLOT_i    (REQ_SLOT_i),
        .REQ_READY_o   (REQ_READY_o),
        .KE_MK_o       (KE_MK_o),
        .KE_MK_VALID_o (KE_MK_VALID_o),
        .KE_RK_i       (KE_RK_i),
        .KE_RK_READY_i (KE_RK_READY_i),
        .RD_SLOT_i     (RD_SLOT_i),
        .RD_DEC_i      (RD_DEC_i),
        .RD_RK_o       (RD_RK_o),
        .SLOT_VALID_o  (SLOT_VALID_o),
        .BUSY_o        (BUSY_o),
`ifdef SM4_KEY_ZEROIZE_EN
        .ZEROIZE_i     (ZEROIZE_i),
`endif
        .ERR_o         (ERR_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int  w;
        bit  hit;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            w   = 31;
            hit = 1'b0;
            for (int i = 0; i < 32; i++) begin
                if (!hit && (got[1023-32*i -: 32] !== exp[1023-32*i -: 32])) begin
                    w   = i;
                    hit = 1'b1;
                end
            end
            $display("FAIL %s word%0d got=%08h exp=%08h @%0t", tag, w,
                     got[1023-32*w -: 32], exp[1023-32*w -: 32], $time);
        end
    endtask

    // Stand-in expansion: deterministic per MK, with the published rk0/rk31 for the test key.
    function automatic logic [1023:0] rk_of(input logic [127:0] mk);
        logic [1023:0] r;
        logic [31:0]   w;
        for (int i = 0; i < 32; i++) begin
            w = mk[127-32*(i%4) -: 32] ^ (32'h9E3779B9 * (i + 1)) ^ {mk[15:0], mk[127:112]};
            r[1023-32*i -: 32] = w;
        end
        if (mk == KMK) begin
            r[1023:992] = 32'hF12186F9;
            r[31:0]     = 32'h9124A012;
        end
        return r;
    endfunction

    function automatic logic [1023:0] dec_order(input logic [1023:0] x);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[1023-32*(31-i) -: 32] = x[1023-32*i -: 32];
        return r;
    endfunction

    // keyexp stub: READY 32 cycles after the launch pulse, RK held afterwards.
    int           stub_cnt = 0;
    bit           stub_en = 1'b1;
    logic [127:0] stub_mk = '0;
    always @(posedge CLK_i) begin
        #1;
        KE_RK_READY_i = (stub_cnt == 1);
        if (stub_cnt == 1) KE_RK_i = rk_of(stub_mk);
        if (stub_cnt > 0) stub_cnt--;
        if (KE_MK_VALID_o === 1'b1 && stub_en) begin
            stub_cnt = 32;
            stub_mk  = KE_MK_o;
        end
    end

    // requester side and reference model
    bit            pend [NR];
    logic [127:0]  pmk  [NR];
    logic [1:0]    pslot[NR];
    int            rand_pct = 0;
    int            grants[$];

    logic [1023:0] m_mem [NS];
    bit            m_vld [NS];
    int            m_ptr;
    bit            m_err;
    logic [127:0]  m_mk;
    bit            inflight;
    bit            acc_stub;
    int            acc_cyc;
    logic [1:0]    acc_slot;
    logic [1023:0] acc_rk;
    int            cyc = 0;

    task automatic model_clear_slots();
        for (int s = 0; s < NS; s++) begin
            m_mem[s] = '0;
            m_vld[s] = 1'b0;
        end
        inflight = 1'b0;
        m_mk     = '0;
    endtask

    task automatic model_reset();
        model_clear_slots();
        m_ptr = 0;
        m_err = 1'b0;
        for (int r = 0; r < NR; r++) pend[r] = 1'b0;
    endtask

    function automatic logic [NS-1:0] m_vld_vec();
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_vld[s];
        return v;
    endfunction

    task automatic run_cycles(input int n);
        bit            rd_ok = 1'b0;
        logic [1023:0] exp_rd = '0;
        logic [NR-1:0] exp_g;
        int            d, g, idx;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK_i); #1;
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && rand_pct > 0 && $urandom_range(99) < rand_pct) begin
                    pend[r]  = 1'b1;
                    pmk[r]   = {$urandom, $urandom, $urandom, $urandom};
                    pslot[r] = 2'($urandom_range(NS-1));
                end
                REQ_VALID_i[r]          = pend[r];
                REQ_MK_i[128*r +: 128]  = pmk[r];
                REQ_SLOT_i[2*r +: 2]    = pslot[r];
            end
            RD_SLOT_i = 2'($urandom_range(NS-1));
            RD_DEC_i  = 1'($urandom_range(1));
            @(negedge CLK_i);
            cyc++;
            d = inflight ? (cyc - acc_cyc) : 0;
            if (inflight && acc_stub && d == 35) begin
                m_mem[acc_slot] = acc_rk;
                m_vld[acc_slot] = 1'b1;
                inflight        = 1'b0;
            end
            if (inflight && !acc_stub && d == 41) begin
                m_err    = 1'b1;
                inflight = 1'b0;
            end
            check_val("busy", BUSY_o, inflight && d >= 1);
            check_val("ke_mk_valid", KE_MK_VALID_o, inflight && d == 1);
            check_val("ke_mk", KE_MK_o, m_mk);
            check_val("slot_valid", SLOT_VALID_o, m_vld_vec());
            check_val("err", ERR_o, m_err);
            if (rd_ok) check_val("rd_rk", RD_RK_o, exp_rd);
            exp_rd = RD_DEC_i ? dec_order(m_mem[RD_SLOT_i]) : m_mem[RD_SLOT_i];
            rd_ok  = 1'b1;
            exp_g = '0;
            g     = -1;
            if (!inflight) begin
                for (int j = 0; j < NR; j++) begin
                    idx = (m_ptr + j) % NR;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            if (g >= 0) exp_g[g] = 1'b1;
            check_val("req_ready", REQ_READY_o, exp_g);
            if (g >= 0) begin
                pend[g]  = 1'b0;
                grants.push_back(g);
                m_ptr    = (g + 1) % NR;
                inflight = 1'b1;
                acc_cyc  = cyc;
                acc_stub = stub_en;
                acc_slot = pslot[g];
                acc_rk   = rk_of(pmk[g]);
                m_mk     = pmk[g];
                m_vld[pslot[g]] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK_i);
        RST_N_i     = 1'b0;
        REQ_VALID_i = '0;
        model_reset();
        repeat (2) @(negedge CLK_i);
        RST_N_i = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, REQ_READY_o, 0);
        check_val({tag, "_mkv"}, KE_MK_VALID_o, 0);
        check_val({tag, "_mk"}, KE_MK_o, 0);
        check_val({tag, "_rd"}, RD_RK_o, 0);
        check_val({tag, "_sv"}, SLOT_VALID_o, 0);
        check_val({tag, "_busy"}, BUSY_o, 0);
        check_val({tag, "_err"}, ERR_o, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge CLK_i);
        @(negedge CLK_i);
        check_all_zero("reset");
        RST_N_i = 1'b1;

        // single load of the published test key into slot 1
        pend[0] = 1'b1; pmk[0] = KMK; pslot[0] = 2'd1;
        grants.delete();
        run_cycles(40);
        check_val("single_grant", (grants.size() == 1) ? grants[0] : 99, 0);
        check_val("single_sv1", SLOT_VALID_o[1], 1);
        @(posedge CLK_i); #1; RD_SLOT_i = 2'd1; RD_DEC_i = 1'b0;
        @(posedge CLK_i); #1; RD_DEC_i = 1'b1;
        @(negedge CLK_i);
        check_val("enc_rk0", RD_RK_o[1023:992], 32'hF12186F9);
        check_val("enc_rk31", RD_RK_o[31:0], 32'h9124A012);
        @(negedge CLK_i);
        check_val("dec_rk0", RD_RK_o[1023:992], 32'h9124A012);
        check_val("dec_rk31", RD_RK_o[31:0], 32'hF12186F9);

        // all four requesters at once from a fresh pointer, then wrap
        do_reset();
        for (int r = 0; r < NR; r++) begin
            pend[r] = 1'b1; pmk[r] = {$urandom, $urandom, $urandom, $urandom}; pslot[r] = 2'(r);
        end
        grants.delete();
        run_cycles(4*35 + 3);
        check_val("rr_count", grants.size(), 4);
        if (grants.size() == 4)
            check_val("rr_order", {grants[0][7:0], grants[1][7:0], grants[2][7:0], grants[3][7:0]}, 32'h00010203);
        pend[2] = 1'b1; pmk[2] = {$urandom, $urandom, $urandom, $urandom}; pslot[2] = 2'd3;
        pend[0] = 1'b1; pmk[0] = {$urandom, $urandom, $urandom, $urandom}; pslot[0] = 2'd0;
        grants.delete();
        run_cycles(75);
        check_val("wrap_first", (grants.size() == 2) ? grants[0] : 99, 0);
        check_val("wrap_second", (grants.size() == 2) ? grants[1] : 99, 2);

        // engine never answers: timeout, slot stays invalid, next load still works
        stub_en = 1'b0;
        pend[1] = 1'b1; pmk[1] = {$urandom, $urandom, $urandom, $urandom}; pslot[1] = 2'd2;
        run_cycles(45);
        check_val("timeout_err", ERR_o, 1);
        check_val("timeout_sv2", SLOT_VALID_o[2], 0);
        stub_en = 1'b1;
        pend[2] = 1'b1; pmk[2] = {$urandom, $urandom, $urandom, $urandom}; pslot[2] = 2'd2;
        run_cycles(40);
        check_val("after_timeout_sv2", SLOT_VALID_o[2], 1);

        // randomized traffic, then drain
        rand_pct = 4;
        run_cycles(900);
        rand_pct = 0;
        run_cycles(160);

        // reset in the middle of WAIT; the late engine READY must not write
        pend[3] = 1'b1; pmk[3] = {$urandom, $urandom, $urandom, $urandom}; pslot[3] = 2'd0;
        run_cycles(11);
        check_val("pre_reset_busy", BUSY_o, 1);
        @(posedge CLK_i); #2;
        RST_N_i     = 1'b0;
        REQ_VALID_i = '0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge CLK_i);
        @(negedge CLK_i);
        RST_N_i = 1'b1;
        run_cycles(40);

`ifdef SM4_KEY_ZEROIZE_EN
        pend[0] = 1'b1; pmk[0] = {$urandom, $urandom, $urandom, $urandom}; pslot[0] = 2'd2;
        run_cycles(40);
        pend[1] = 1'b1; pmk[1] = {$urandom, $urandom, $urandom, $urandom}; pslot[1] = 2'd3;
        run_cycles(12);
        @(posedge CLK_i); #1; ZEROIZE_i = 1'b1;
        @(posedge CLK_i); #1; ZEROIZE_i = 1'b0;
        @(negedge CLK_i);
        check_val("zero_sv", SLOT_VALID_o, 0);
        check_val("zero_rd", RD_RK_o, 0);
        check_val("zero_busy", BUSY_o, 0);
        check_val("zero_mk", KE_MK_o, 0);
        model_clear_slots();
        run_cycles(40);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
